fifo_burst_reader: RTL and testbench
====================================

// Module: fifo_burst_reader
// PURPOSE
//  Read-side controller for the sync FIFO. On a start command it drains exactly
//  len words from the FIFO read port (rd_en/data_out/valid/empty) and presents
//  them on a valid/ready stream through a 2-entry skid buffer.
//  Sits between the FIFO and the downstream consumer. Gives full throughput
//  with backpressure, and never issues a read to an empty FIFO.
// PARAMETERS
//  FIFO_WIDTH  16  data width, matches FIFO data_in/data_out
//  LEN_W       8   width of burst length and word counter
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           async reset, active-high
//  start          in   1           burst request, sampled only in IDLE
//  len            in   LEN_W       burst length in words, sampled with start
//  busy           out  1           high in READ/DRAIN/DONE
//  done           out  1           1-cycle pulse at burst completion
//  proto_err      out  1           sticky FIFO protocol error
//  fifo_rd_en     out  1           FIFO read enable (combinational)
//  fifo_empty     in   1           FIFO empty flag
//  fifo_valid     in   1           FIFO data_out valid, 1 cycle after rd_en
//  fifo_data_out  in   FIFO_WIDTH  FIFO read data
//  m_valid        out  1           stream valid
//  m_ready        in   1           stream ready
//  m_data         out  FIFO_WIDTH  stream data = skid buffer head
//  rd_count       out  LEN_W       words handed off so far in this burst
// BEHAVIOUR
//  Reset: state=IDLE; skid buffer emptied; issued/inflight/rd_count=0.
//   busy, done, proto_err, m_valid=0; m_data=0; fifo_rd_en=0.
//   Reset mid-burst aborts the burst: buffered data is dropped, no done pulse.
//  FSM:
//   IDLE  -> start&&len!=0: latch len, clear rd_count and proto_err; go READ.
//   IDLE  -> start&&len==0: go DONE, no FIFO reads.
//   READ  -> issued==len at clock edge: go DRAIN.
//   DRAIN -> inflight==0 && buffer empty: go DONE.
//   DONE  -> unconditionally back to IDLE; done=1 only while in DONE.
//   start outside IDLE is ignored.
//  Read issue: fifo_rd_en = (state==READ) && !fifo_empty && issued<len
//   && (occ + inflight - (m_valid&&m_ready)) < 2.
//   This creates a combinational path m_ready -> fifo_rd_en (intended).
//   occ = skid occupancy 0..2. inflight = 1 if rd_en was asserted last cycle.
//  Capture: fifo_valid && inflight writes fifo_data_out into the skid tail.
//   Capture and pop in the same cycle are both honoured.
//   Buffer order is FIFO order; overflow is impossible under the issue rule.
//  Latency: first rd_en is in the cycle after start is sampled.
//   m_valid rises 2 cycles after a given rd_en when the buffer is empty.
//   Sustains 1 word/cycle while m_ready=1.
//  Stream rules: once m_valid=1, m_valid and m_data are held until m_ready=1.
//   Each handshake increments rd_count. rd_count holds its final value until
//   the next accepted start.
//  proto_err: set when fifo_valid&&!inflight or inflight&&!fifo_valid.
//   Sticky until rst or an accepted start. The burst continues regardless.
//  fifo_empty seen high in READ: stall with no read; busy stays 1, no timeout.
// TESTING
//  1 FIFO holds A1..A4, start len=4, m_ready=1 -> rd_en 4 consecutive cycles;
//    m_data A1,A2,A3,A4 on consecutive cycles; done 1 cycle after last handshake;
//    rd_count=4.
//  2 len=6, FIFO full, m_ready=0 -> exactly 2 rd_en pulses, m_data stable at
//    the 1st word; m_ready=1 -> remaining 4 reads, in order, no loss or duplication.
//  3 start len=3 with FIFO empty -> no rd_en, busy=1; write 0x55 -> one read,
//    m_data=0x55; write 2 more -> done, rd_count=3.
//  4 start len=0 -> done the next cycle, no rd_en, rd_count=0.
//  5 rst=1 mid-burst after 2 of 5 words -> all outputs 0 immediately, with no
//    clock edge; the next start len=1 works normally.
//  6 fifo_valid pulsed with no rd_en -> proto_err=1 and stays 1;
//    an accepted start clears it.

Source files
------------

// File: rtl/fifo_burst_reader_if.sv
// +-------------------------------------------------------------------+
// | fifo_burst_reader_if: command, FIFO read port and output stream   |
// | bundle for fifo_burst_reader.                        Rev 1.0      |
// +-------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface fifo_burst_reader_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int LEN_W      = 8
);
  logic                  start;
  logic [LEN_W-1:0]      len;
  logic                  busy;
  logic                  done;
  logic                  proto_err;
  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic                  fifo_valid;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  m_valid;
  logic                  m_ready;
  logic [FIFO_WIDTH-1:0] m_data;
  logic [LEN_W-1:0]      rd_count;

  // master: the burst reader itself
  modport master (
    input  start, len, fifo_empty, fifo_valid, fifo_data_out, m_ready,
    output busy, done, proto_err, fifo_rd_en, m_valid, m_data, rd_count
  );

  // slave: the surrounding FIFO, command source and stream consumer
  modport slave (
    output start, len, fifo_empty, fifo_valid, fifo_data_out, m_ready,
    input  busy, done, proto_err, fifo_rd_en, m_valid, m_data, rd_count
  );
endinterface

`default_nettype wire

// File: rtl/fifo_burst_reader.sv
// +-------------------------------------------------------------------+
// | fifo_burst_reader: drains a len-word burst from a sync FIFO into  |
// | a valid/ready stream through a 2-entry skid buffer.  Rev 1.0      |
// +-------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fifo_burst_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int LEN_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  fifo_burst_reader_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_issued;
  logic [LEN_W-1:0]      r_count;
  logic                  r_inflight;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_proto_err;
  logic [1:0]            r_occ;
  logic [FIFO_WIDTH-1:0] r_head;
  logic [FIFO_WIDTH-1:0] r_tail;

  logic                  w_pop;
  logic                  w_cap;
  logic                  w_start_acc;
  logic                  w_rd_en;
  logic [2:0]            w_load;
  logic [1:0]            w_occ_next;

  assign w_pop       = (r_occ != 2'd0) && bus.m_ready;
  assign w_cap       = bus.fifo_valid && r_inflight;
  assign w_start_acc = (r_state == S_IDLE) && bus.start;
  // Words held or on their way after this edge; a new read must still fit.
  assign w_load      = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en     = (r_state == S_READ) && !bus.fifo_empty &&
                       (r_issued < r_len) && (w_load < 3'd2);
  assign w_occ_next  = r_occ + {1'b0, w_cap} - {1'b0, w_pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ      <= 2'd0;
      r_head     <= '0;
      r_tail     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      r_occ      <= w_occ_next;
      if (w_pop && (r_occ == 2'd2))
        r_head <= r_tail;
      else if (w_cap && ((r_occ == 2'd0) || (w_pop && (r_occ == 2'd1))))
        r_head <= bus.fifo_data_out;
      if (w_cap && (((r_occ == 2'd1) && !w_pop) || ((r_occ == 2'd2) && w_pop)))
        r_tail <= bus.fifo_data_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_issued    <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_proto_err <= (bus.fifo_valid != r_inflight) ||
                     (r_proto_err && !w_start_acc);
      if (w_rd_en)
        r_issued <= r_issued + LEN_W'(1);
      if (w_pop)
        r_count <= r_count + LEN_W'(1);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_len    <= bus.len;
            r_issued <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            if (bus.len != '0) begin
              r_state <= S_READ;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (r_issued == r_len)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Leave as soon as the last word is handed off this cycle.
          if (!r_inflight && (w_occ_next == 2'd0)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.proto_err  = r_proto_err;
  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = (r_occ != 2'd0);
  assign bus.m_data     = r_head;
  assign bus.rd_count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// +-------------------------------------------------------------------+
// | tb_fifo_burst_reader: self-checking bench with a sync FIFO model  |
// | and an in-order word scoreboard.                     Rev 1.0      |
// +-------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_burst_reader;
  localparam int FW = 16;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_burst_reader_if #(.FIFO_WIDTH(FW), .LEN_W(LW)) bus ();
  fifo_burst_reader #(.FIFO_WIDTH(FW), .LEN_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Sync FIFO model: data and valid appear one cycle after rd_en.
  logic [FW-1:0] mem [0:1023];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic inject_valid = 1'b0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr            <= wr_ptr;
      bus.fifo_valid    <= 1'b0;
      bus.fifo_data_out <= '0;
    end else begin
      bus.fifo_valid <= (bus.fifo_rd_en && (wr_ptr != rd_ptr)) || inject_valid;
      if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
        bus.fifo_data_out <= mem[rd_ptr % 1024];
        rd_ptr            <= rd_ptr + 1;
      end
    end
  end

  task automatic push(input logic [FW-1:0] d);
    mem[wr_ptr % 1024] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  // Observation recorder; a change of tok restarts all records.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tok = 0;
  int seen_tok = 0;
  int rd_cnt, rd_on_empty, hold_viol, done_cnt;
  int first_rd, last_rd, first_hs, last_hs, done_cyc;
  logic [FW-1:0] got_q[$];
  logic          prev_stall = 1'b0;
  logic [FW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (tok != seen_tok) begin
      seen_tok = tok;
      rd_cnt = 0; rd_on_empty = 0; hold_viol = 0; done_cnt = 0;
      first_rd = -1; last_rd = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
      got_q.delete();
    end
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.fifo_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        rd_cnt++;
        if (bus.fifo_empty) rd_on_empty++;
      end
      if (prev_stall && (!bus.m_valid || (bus.m_data !== prev_data))) hold_viol++;
      if (bus.m_valid && bus.m_ready) begin
        got_q.push_back(bus.m_data);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  task automatic start_burst(input int l, output int st);
    tok++;
    bus.start = 1'b1;
    bus.len   = LW'(l);
    st        = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      if (done_cnt != 0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.len = '0; bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", bus.proto_err); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    checks++; if (bus.m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
    checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
    checks++; if (bus.rd_count !== '0) begin errors++; $display("FAIL reset_rd_count: got %0d want 0", bus.rd_count); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [FW-1:0] w [4];
    int st; bit ok;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin w[i] = FW'($urandom); push(w[i]); end
    bus.m_ready = 1'b1;
    start_burst(4, st);
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: no done within 40 cycles"); end
    checks++; if (rd_cnt != 4 || last_rd - first_rd != 3) begin errors++; $display("FAIL basic_rd_en: got %0d pulses span %0d want 4 span 3", rd_cnt, last_rd - first_rd); end
    checks++; if (first_rd != st + 1) begin errors++; $display("FAIL basic_first_rd: got cycle %0d want %0d", first_rd, st + 1); end
    checks++; if (first_hs != first_rd + 2 || last_hs - first_hs != 3) begin errors++; $display("FAIL basic_stream_timing: got first %0d span %0d want %0d span 3", first_hs, last_hs - first_hs, first_rd + 2); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_q.size() <= i || got_q[i] !== w[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, (got_q.size() > i) ? got_q[i] : 'x, w[i]); end
    end
    checks++; if (done_cyc != last_hs + 1) begin errors++; $display("FAIL basic_done_timing: got cycle %0d want %0d", done_cyc, last_hs + 1); end
    checks++; if (bus.rd_count !== LW'(4)) begin errors++; $display("FAIL basic_rd_count: got %0d want 4", bus.rd_count); end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] w [6];
    int st; bit ok;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin w[i] = FW'($urandom); push(w[i]); end
    bus.m_ready = 1'b0;
    start_burst(6, st);
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (rd_cnt != 2) begin errors++; $display("FAIL bp_stalled_reads: got %0d want 2", rd_cnt); end
    checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== w[0]) begin errors++; $display("FAIL bp_head: got v=%b d=%h want v=1 d=%h", bus.m_valid, bus.m_data, w[0]); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b want 1", bus.busy); end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: no done within 60 cycles"); end
    checks++; if (rd_cnt != 6 || got_q.size() != 6) begin errors++; $display("FAIL bp_counts: got %0d reads %0d words want 6 and 6", rd_cnt, got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (got_q.size() <= i || got_q[i] !== w[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, (got_q.size() > i) ? got_q[i] : 'x, w[i]); end
    end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold: got %0d hold violations want 0", hold_viol); end
    checks++; if (bus.rd_count !== LW'(6)) begin errors++; $display("FAIL bp_rd_count: got %0d want 6", bus.rd_count); end
  endtask

  task automatic test_empty_stall();
    logic [FW-1:0] w [3];
    int st; bit ok;
    @(posedge clk); #1;
    w[0] = 16'h0055; w[1] = FW'($urandom); w[2] = FW'($urandom);
    bus.m_ready = 1'b1;
    start_burst(3, st);
    repeat (6) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (rd_cnt != 0 || rd_on_empty != 0) begin errors++; $display("FAIL empty_no_read: got %0d reads want 0", rd_cnt); end
    checks++; if (bus.busy !== 1'b1 || done_cnt != 0) begin errors++; $display("FAIL empty_busy: got busy=%b done=%0d want 1 and 0", bus.busy, done_cnt); end
    @(posedge clk); #1;
    push(w[0]);
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (rd_cnt != 1 || got_q.size() != 1 || got_q[0] !== 16'h0055) begin errors++; $display("FAIL empty_first_word: got %0d reads %0d words want 1 read of 0055", rd_cnt, got_q.size()); end
    @(posedge clk); #1;
    push(w[1]); push(w[2]);
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL empty_timeout: no done within 40 cycles"); end
    checks++; if (got_q.size() != 3 || got_q[1] !== w[1] || got_q[2] !== w[2]) begin errors++; $display("FAIL empty_data: got %0d words want %h %h after 0055", got_q.size(), w[1], w[2]); end
    checks++; if (bus.rd_count !== LW'(3)) begin errors++; $display("FAIL empty_rd_count: got %0d want 3", bus.rd_count); end
  endtask

  task automatic test_zero_len();
    int st; bit ok;
    @(posedge clk); #1;
    start_burst(0, st);
    wait_done(10, ok);
    checks++; if (!ok || done_cyc != st + 1) begin errors++; $display("FAIL zero_done: got cycle %0d want %0d", done_cyc, st + 1); end
    checks++; if (rd_cnt != 0) begin errors++; $display("FAIL zero_reads: got %0d want 0", rd_cnt); end
    checks++; if (bus.rd_count !== '0) begin errors++; $display("FAIL zero_rd_count: got %0d want 0", bus.rd_count); end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (done_cnt != 1 || bus.busy !== 1'b0) begin errors++; $display("FAIL zero_idle: got done pulses %0d busy %b want 1 and 0", done_cnt, bus.busy); end
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] w1;
    int st; bit ok;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) push(FW'($urandom));
    bus.m_ready = 1'b1;
    start_burst(5, st);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (got_q.size() >= 2) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_progress: got %0d words want 2", got_q.size()); end
    rst = 1'b1;
    #1;
    checks++; if ({bus.busy, bus.done, bus.proto_err, bus.m_valid, bus.fifo_rd_en} !== 5'b0) begin errors++; $display("FAIL rstmid_flags: got %b want 00000", {bus.busy, bus.done, bus.proto_err, bus.m_valid, bus.fifo_rd_en}); end
    checks++; if (bus.m_data !== '0 || bus.rd_count !== '0) begin errors++; $display("FAIL rstmid_values: got data %h count %0d want 0 and 0", bus.m_data, bus.rd_count); end
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d done pulses want 0", done_cnt); end
    @(posedge clk); #1;
    w1 = FW'($urandom);
    push(w1);
    start_burst(1, st);
    wait_done(30, ok);
    checks++; if (!ok || got_q.size() != 1 || got_q[0] !== w1) begin errors++; $display("FAIL rstmid_next_burst: got %0d words first %h want 1 word %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 'x, w1); end
    checks++; if (bus.rd_count !== LW'(1)) begin errors++; $display("FAIL rstmid_rd_count: got %0d want 1", bus.rd_count); end
  endtask

  task automatic test_proto_err();
    logic [FW-1:0] w1;
    int st; bit ok;
    @(posedge clk); #1;
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL perr_clean: got %b want 0", bus.proto_err); end
    inject_valid = 1'b1;
    @(posedge clk); #1;
    inject_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL perr_set: got %b want 1", bus.proto_err); end
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b want 1", bus.proto_err); end
    @(posedge clk); #1;
    w1 = FW'($urandom);
    push(w1);
    bus.m_ready = 1'b1;
    start_burst(1, st);
    @(negedge clk); #1;
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL perr_clear: got %b want 0", bus.proto_err); end
    @(posedge clk); #1;
    wait_done(30, ok);
    checks++; if (!ok || got_q.size() != 1 || got_q[0] !== w1) begin errors++; $display("FAIL perr_burst: got %0d words want 1 word %h", got_q.size(), w1); end
  endtask

  // Random lengths, late arrivals and random backpressure, bursts back to back.
  task automatic test_back_to_back();
    logic [FW-1:0] exp_q[$];
    int l, pushed, st, bad;
    bit ok;
    @(posedge clk); #1;
    for (int b = 0; b < 8; b++) begin
      l = $urandom_range(1, 24);
      exp_q.delete();
      pushed = $urandom_range(0, l);
      for (int i = 0; i < pushed; i++) begin exp_q.push_back(FW'($urandom)); push(exp_q[i]); end
      bus.m_ready = ($urandom_range(0, 2) != 0);
      start_burst(l, st);
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk); #1;
        if (done_cnt != 0) begin ok = 1'b1; break; end
        @(posedge clk); #1;
        bus.m_ready = ($urandom_range(0, 2) != 0);
        if (pushed < l && $urandom_range(0, 1) == 1) begin
          exp_q.push_back(FW'($urandom)); push(exp_q[pushed]); pushed++;
        end
      end
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout[%0d]: len %0d no done within 400 cycles", b, l); end
      bad = -1;
      for (int i = 0; i < l; i++) if (bad < 0 && (got_q.size() <= i || got_q[i] !== exp_q[i])) bad = i;
      checks++; if (got_q.size() != l || bad >= 0) begin errors++; $display("FAIL b2b_data[%0d]: got %0d words first bad index %0d want %0d words in order", b, got_q.size(), bad, l); end
      checks++; if (bus.rd_count !== LW'(l) || rd_cnt != l) begin errors++; $display("FAIL b2b_counts[%0d]: got rd_count %0d reads %0d want %0d", b, bus.rd_count, rd_cnt, l); end
      checks++; if (rd_on_empty != 0 || hold_viol != 0 || bus.proto_err !== 1'b0) begin errors++; $display("FAIL b2b_rules[%0d]: got empty reads %0d hold viol %0d perr %b want 0 0 0", b, rd_on_empty, hold_viol, bus.proto_err); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.len   = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_zero_len();
    test_reset_mid();
    test_proto_err();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
